// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter (1 or 2 stop bits): a holding register feeds a shift register.
// TXD is registered; a byte held during the stop bit starts its frame with no idle gap.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int STOP_BITS   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       busy,
  output logic       TXD
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  if ((STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2) begin : g_param_check
    $error("uart_tx: STOP_BITS must be 1 or 2 and CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic             txd_q;
  logic             bit_done;

  assign bit_done = (baud_cnt_q == DIV_M1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      // Holding-register load; never coincides with a transfer, which needs hold_full_q set.
      if (wr_valid && !hold_full_q) begin
        hold_q      <= wr_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          txd_q      <= 1'b1;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= START;
            txd_q       <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            state_q    <= DATA;
            txd_q      <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
              txd_q     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= START;
                txd_q       <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready = ~hold_full_q;
  assign busy     = (state_q != IDLE) || hold_full_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: one instance with one stop bit, one with two.
// Line levels are compared bit-by-bit against expected frames built from the written byte.
module tb_uart_tx;

  localparam int DIV = 10;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] wr_data1, wr_data2;
  logic       wr_valid1, wr_valid2;
  logic       wr_ready1, wr_ready2;
  logic       busy1, busy2;
  logic       txd1, txd2;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 CLK = ~CLK;

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .wr_data(wr_data1), .wr_valid(wr_valid1),
    .wr_ready(wr_ready1), .busy(busy1), .TXD(txd1)
  );

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .wr_data(wr_data2), .wr_valid(wr_valid2),
    .wr_ready(wr_ready2), .busy(busy2), .TXD(txd2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Write one byte into an idle transmitter; returns just after the START-entry edge.
  task automatic start_write(input string tag, input bit sel2, input logic [7:0] d);
    if (sel2) begin wr_valid2 = 1'b1; wr_data2 = d; end
    else      begin wr_valid1 = 1'b1; wr_data1 = d; end
    tick();
    if (sel2) wr_valid2 = 1'b0; else wr_valid1 = 1'b0;
    check($sformatf("%s_acc_rdy", tag),  sel2 ? wr_ready2 : wr_ready1, 0);
    check($sformatf("%s_acc_busy", tag), sel2 ? busy2 : busy1, 1);
    check($sformatf("%s_acc_txd", tag),  sel2 ? txd2 : txd1, 1);
    tick();
  endtask

  // Sample one whole frame starting right after its START-entry edge.
  task automatic frame_chk(input string tag, input bit sel2, input logic [7:0] exp,
                           input int nstop, input bit idle_after, input bit keep_vld);
    int         nbits = 9 + nstop;
    int         bad [11];
    logic [7:0] got = 8'h00;
    bit         acc;
    logic       txd;
    logic       lvl;
    int         b;
    for (int i = 0; i < 11; i++) bad[i] = 0;
    acc = !sel2 && wr_valid1;
    for (int k = 0; k < nbits * DIV; k++) begin
      b   = k / DIV;
      txd = sel2 ? txd2 : txd1;
      if (b == 0)      lvl = 1'b0;
      else if (b <= 8) lvl = exp[b-1];
      else             lvl = 1'b1;
      if (txd !== lvl) bad[b]++;
      if (b >= 1 && b <= 8 && (k % DIV) == DIV / 2) got[b-1] = txd;
      if (k == 0) check($sformatf("%s_rdy0", tag), sel2 ? wr_ready2 : wr_ready1, 1);
      if (k == 1) begin
        check($sformatf("%s_rdy1", tag), sel2 ? wr_ready2 : wr_ready1, {31'd0, !acc});
        if (!sel2) begin
          if (keep_vld) wr_data1 = 8'hFF;
          else          wr_valid1 = 1'b0;
        end
      end
      if (k == nbits * DIV - 1) check($sformatf("%s_busy_end", tag), sel2 ? busy2 : busy1, 1);
      tick();
    end
    for (int i = 0; i < nbits; i++) check($sformatf("%s_bit%0d_bad", tag, i), bad[i], 0);
    check($sformatf("%s_byte", tag), got, exp);
    check($sformatf("%s_busy_after", tag), sel2 ? busy2 : busy1, {31'd0, !idle_after});
    check($sformatf("%s_txd_after", tag), sel2 ? txd2 : txd1, {31'd0, idle_after});
  endtask

  initial begin
    int bad_idle;
    RESET     = 1'b0;
    wr_valid1 = 1'b0;
    wr_valid2 = 1'b0;
    wr_data1  = 8'h00;
    wr_data2  = 8'h00;
    #2 RESET = 1'b1;
    #1;
    check("rst_txd1", txd1, 1);
    check("rst_rdy1", wr_ready1, 1);
    check("rst_busy1", busy1, 0);
    check("rst_txd2", txd2, 1);
    check("rst_busy2", busy2, 0);
    tick(); tick(); tick();
    RESET = 1'b0;

    bad_idle = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd1 !== 1'b1 || wr_ready1 !== 1'b1 || busy1 !== 1'b0) bad_idle++;
      if (txd2 !== 1'b1 || wr_ready2 !== 1'b1 || busy2 !== 1'b0) bad_idle++;
      tick();
    end
    check("idle_100", bad_idle, 0);

    start_write("f55", 1'b0, 8'h55);
    frame_chk("f55", 1'b0, 8'h55, 1, 1'b1, 1'b0);
    tick();

    // Back-to-back: second byte offered as soon as wr_ready returns.
    start_write("bb1", 1'b0, 8'hA3);
    wr_valid1 = 1'b1;
    wr_data1  = 8'h0F;
    frame_chk("bbA3", 1'b0, 8'hA3, 1, 1'b0, 1'b0);
    frame_chk("bb0F", 1'b0, 8'h0F, 1, 1'b1, 1'b0);
    tick();

    // wr_valid held high with 0xFF while the holding register already holds 0x22.
    start_write("hold", 1'b0, 8'h11);
    wr_valid1 = 1'b1;
    wr_data1  = 8'h22;
    frame_chk("h11", 1'b0, 8'h11, 1, 1'b0, 1'b1);
    frame_chk("h22", 1'b0, 8'h22, 1, 1'b0, 1'b0);
    frame_chk("hFF", 1'b0, 8'hFF, 1, 1'b1, 1'b0);
    tick();

    start_write("s2", 1'b1, 8'h00);
    frame_chk("s2_00", 1'b1, 8'h00, 2, 1'b1, 1'b0);
    tick();

    // Asynchronous reset in the middle of a 0x81 frame.
    start_write("r81", 1'b0, 8'h81);
    for (int i = 0; i < 35; i++) tick();
    check("mid_txd_low", txd1, 0);
    #2 RESET = 1'b1;
    #1;
    check("arst_txd", txd1, 1);
    check("arst_rdy", wr_ready1, 1);
    check("arst_busy", busy1, 0);
    tick(); tick();
    RESET = 1'b0;
    tick();
    check("post_rst_busy", busy1, 0);
    start_write("r3C", 1'b0, 8'h3C);
    frame_chk("r3C", 1'b0, 8'h3C, 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
